// File: rtl/idli_sregs_m_if.sv
// Operand/write bus of the slice-serial register file: two read selects,
// one slice-wide write port and the beat/word-boundary status.
interface idli_sregs_m_if #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16,
  parameter int SLICE_W  = 4
) ();
  localparam int SEL_W  = $clog2(NUM_REGS);
  localparam int NSLICE = REG_W / SLICE_W;
  localparam int BEAT_W = $clog2(NSLICE);

  logic [SEL_W-1:0]   i_reg_lhs;
  logic [SLICE_W-1:0] o_reg_lhs_data;
  logic [SEL_W-1:0]   i_reg_rhs;
  logic [SLICE_W-1:0] o_reg_rhs_data;
  logic               i_reg_wr_en;
  logic [SEL_W-1:0]   i_reg_wr_reg;
  logic [SLICE_W-1:0] i_reg_wr_data;
  logic               o_reg_wr_ack;
  logic               o_reg_wr_busy;
  logic [BEAT_W-1:0]  o_reg_beat;
  logic               o_reg_first;
  logic               o_reg_last;

  modport slave (
    input  i_reg_lhs, i_reg_rhs, i_reg_wr_en, i_reg_wr_reg, i_reg_wr_data,
    output o_reg_lhs_data, o_reg_rhs_data, o_reg_wr_ack, o_reg_wr_busy,
    output o_reg_beat, o_reg_first, o_reg_last
  );

  modport master (
    output i_reg_lhs, i_reg_rhs, i_reg_wr_en, i_reg_wr_reg, i_reg_wr_data,
    input  o_reg_lhs_data, o_reg_rhs_data, o_reg_wr_ack, o_reg_wr_busy,
    input  o_reg_beat, o_reg_first, o_reg_last
  );
endinterface

// File: rtl/idli_sregs_m.sv
// Slice-serial register file: every register rotates one slice per cycle,
// a write replaces a whole register over one word period starting on beat 0.
module idli_sregs_m #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16,
  parameter int SLICE_W  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic          i_reg_gck,
  input  logic          i_reg_rst_n,
  idli_sregs_m_if.slave bus
);
  localparam int NSLICE = REG_W / SLICE_W;
  localparam int SEL_W  = $clog2(NUM_REGS);
  localparam int BEAT_W = $clog2(NSLICE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NSLICE - 1);

  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BEAT_W-1:0]  r_beat;
  logic [SEL_W-1:0]   r_wr_reg;
  logic               w_accept;
  logic               w_active;
  logic [SEL_W-1:0]   w_dest;
  logic [SLICE_W-1:0] w_low [NUM_REGS];

  assign w_accept = (r_beat == '0) && bus.i_reg_wr_en;
  assign w_active = w_accept || (r_state == ST_WRITE);
  // On the accept cycle the destination is not latched yet, so use the live select.
  assign w_dest   = w_accept ? bus.i_reg_wr_reg : r_wr_reg;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_WRITE;
      ST_WRITE: if (r_beat == LAST_BEAT) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_reg_gck) begin
    if (!i_reg_rst_n) begin
      r_state  <= ST_IDLE;
      r_beat   <= '0;
      r_wr_reg <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
      if (w_accept) r_wr_reg <= bus.i_reg_wr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign w_low[gi] = '0;
      end else begin : g_reg
        logic [REG_W-1:0]   r_reg;
        logic [SLICE_W-1:0] w_in;

        assign w_in = (w_active && w_dest == SEL_W'(gi)) ? bus.i_reg_wr_data
                                                          : r_reg[SLICE_W-1:0];

        always_ff @(posedge i_reg_gck) begin
          if (!i_reg_rst_n) r_reg <= '0;
          else              r_reg <= {w_in, r_reg[REG_W-1:SLICE_W]};
        end

        assign w_low[gi] = r_reg[SLICE_W-1:0];
      end
    end
  endgenerate

  // Hardwired zero wins over bypass so register 0 never leaks write data.
  function automatic logic [SLICE_W-1:0] read_slice(input logic [SEL_W-1:0] sel);
    logic [SLICE_W-1:0] data;
    data = w_low[sel];
    if (w_active && sel == w_dest) data = bus.i_reg_wr_data;
    if (ZERO_REG != 0 && sel == '0) data = '0;
    return data;
  endfunction

  assign bus.o_reg_lhs_data = read_slice(bus.i_reg_lhs);
  assign bus.o_reg_rhs_data = read_slice(bus.i_reg_rhs);
  assign bus.o_reg_wr_ack   = w_accept;
  assign bus.o_reg_wr_busy  = w_active;
  assign bus.o_reg_beat     = r_beat;
  assign bus.o_reg_first    = (r_beat == '0);
  assign bus.o_reg_last     = (r_beat == LAST_BEAT);
endmodule
